// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end constants and the fetch queue occupancy type.
package legv8_pkg;

    localparam int INSTR_W      = 32;
    localparam int ADDR_W       = 32;
    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 22;
    localparam int FETCHQ_DEPTH = 4;

    localparam int OPCODE_W     = OPCODE_MSB - OPCODE_LSB + 1;

    // Occupancy of the fetch queue; mirrors the count register.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } fetchq_occ_e;

endpackage

// File: rtl/fetchq_storage.sv
// Entry array for the fetch queue: synchronous write, asynchronous read.
module fetchq_storage #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write the presented entry at the write pointer.
    // NOTE: the array is deliberately not reset; validity is tracked by the
    // occupancy count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue between instruction memory and decode.
// Holds PC/instruction pairs in push order; flush discards everything.
module instr_fetch_queue
    import legv8_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH,  // power of two, >= 2
    parameter int WIDTH = INSTR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_pc,
    input  logic [WIDTH-1:0]           in_instr,
    output logic                       in_ready,
    output logic                       pc_stall,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_pc,
    output logic [WIDTH-1:0]           out_instr,
    output logic [OPCODE_W-1:0]        out_opcode,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    fetchq_occ_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push, pop;
    logic [2*WIDTH-1:0] rd_data;

    // Handshake: ready/valid come from registered occupancy only, so there
    // is no combinational path from in_* or out_ready to these outputs.
    assign in_ready  = (state_q != OCC_FULL);
    assign pc_stall  = ~in_ready;
    assign out_valid = (state_q != OCC_EMPTY);
    assign push      = in_valid  & in_ready  & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    assign out_pc     = out_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
    assign out_instr  = out_valid ? rd_data[WIDTH-1:0]       : '0;
    assign out_opcode = out_instr[OPCODE_MSB:OPCODE_LSB];
    assign count      = count_q;

    fetchq_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH),
        .PTR_W  (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    // State register: occupancy, count and both pointers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= OCC_EMPTY;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Next-state logic: flush clears everything, otherwise push/pop move
    // the pointers (wrapping naturally at DEPTH) and the occupancy state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (flush) begin
            state_d  = OCC_EMPTY;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            case (state_q)
                OCC_EMPTY: begin
                    if (push) begin
                        state_d = OCC_PARTIAL;
                    end
                end
                OCC_PARTIAL: begin
                    if (count_d == '0) begin
                        state_d = OCC_EMPTY;
                    end else if (count_d == FULL_COUNT) begin
                        state_d = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        state_d = OCC_PARTIAL;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of two and at least 2.
REQ-002 Parameter WIDTH, default 32, instruction and PC width in bits.
REQ-003 clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  fetch side presents a PC/instruction pair.
REQ-006 in_pc  input  WIDTH  address of the presented instruction.
REQ-007 in_instr  input  WIDTH  instruction word from instruction memory.
REQ-008 in_ready  output  1  queue can accept a word this cycle.
REQ-009 pc_stall  output  1  tells the program counter to hold; equals NOT in_ready.
REQ-010 flush  input  1  branch taken; discard all queued and incoming words.
REQ-011 out_valid  output  1  head entry is valid for decode.
REQ-012 out_pc  output  WIDTH  PC of the head entry.
REQ-013 out_instr  output  WIDTH  instruction of the head entry.
REQ-014 out_opcode  output  10  out_instr[31:22], fed to the controller.
REQ-015 out_ready  input  1  decode consumes the head this cycle.
REQ-016 count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-017 A push SHALL occur when in_valid AND in_ready AND NOT flush.
REQ-018 A pop SHALL occur when out_valid AND out_ready AND NOT flush.
REQ-019 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend on out_ready.
REQ-020 out_valid SHALL be 1 exactly when count > 0.
REQ-021 A word pushed in cycle N SHALL appear at out_* no earlier than cycle N+1; there is no combinational path from in_* to out_*.
REQ-022 out_pc and out_instr SHALL be driven from the entry at the read pointer, and SHALL be 0 when out_valid is 0.
REQ-023 Entries SHALL leave in strict push order.
REQ-024 Write and read pointers SHALL wrap modulo DEPTH.
REQ-025 Occupancy states: EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
REQ-026 Simultaneous push and pop in PARTIAL SHALL leave count unchanged and keep the state.
REQ-027 In EMPTY only a push is possible; the next state is PARTIAL.
REQ-028 In FULL only a pop is possible; the next state is PARTIAL. in_valid held in FULL is a legal stall and SHALL NOT corrupt state.
REQ-029 When count reaches DEPTH, pc_stall SHALL assert in the following cycle; the fetch side holds in_pc and in_instr stable until pc_stall deasserts.
REQ-030 flush SHALL, in the next cycle, set count=0 and both pointers=0.
REQ-031 flush SHALL override push and pop in the same cycle; the concurrent in_* word SHALL be dropped.
REQ-032 Stored entry contents need not be cleared by flush or reset.

Reset
REQ-033 When reset is asserted at a rising edge: count=0, pointers=0, out_valid=0, out_pc=0, out_instr=0, out_opcode=0, in_ready=1, pc_stall=0.
REQ-034 reset SHALL take priority over flush, push and pop, including mid-operation with the queue FULL.
REQ-035 in_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-036 The shared package legv8_pkg SHALL hold INSTR_W=32, ADDR_W=32, OPCODE_MSB=31, OPCODE_LSB=22, and FETCHQ_DEPTH=4.
REQ-037 The module SHALL contain one sub-module, fetchq_storage: a DEPTH x (2*WIDTH) register array with a synchronous write port and an asynchronous read port.
REQ-038 Pointer, count and handshake logic SHALL be in instr_fetch_queue itself.

Verification
REQ-039 Sequence:
  - reset for 2 cycles, then push pc=0, instr=0x8B020020;
  - next cycle: out_valid=1, out_pc=0, out_instr=0x8B020020, out_opcode=0x22C, count=1.
REQ-040 Sequence:
  - hold out_ready=0 and push pc=0,4,8,12;
  - then: count=4, in_ready=0, pc_stall=1;
  - a fifth push of pc=16 SHALL be held, not lost;
  - after one pop, pc=16 is accepted and the output order is 0,4,8,12,16.
REQ-041 Sequence:
  - count=2, with push and pop in the same cycle for 10 cycles using pc=100,104,...;
  - count stays 2, with no loss or duplication across pointer wrap.
REQ-042 Sequence:
  - count=3, then flush=1 while in_valid=1 and out_ready=1;
  - next cycle: count=0, out_valid=0, out_instr=0;
  - the in-flight word is absent from the queue.
REQ-043 Sequence:
  - queue FULL, then reset asserted for 1 cycle;
  - next cycle: all outputs at their reset values;
  - a subsequent push of pc=200 emerges one cycle later.
REQ-044 Sequence:
  - random in_valid/out_ready at 50% for 2000 cycles, with random flush at 2%;
  - the output stream equals a reference model, and count never exceeds DEPTH.
